mdu_sched: RTL and testbench

Scheduler that shares the single multiplier and divider pair between the two issue pipelines (requester 0 = alpha, requester 1 = beta). It accepts MULT/MULTU/DIV/DIVU requests and arbitrates them round-robin. It launches the selected unit with a one-cycle op pulse, tracks the unit's `done` handshake, and commits the 64-bit result to HI/LO exactly once. Pipelines stall on it while their request is pending, and while an MFHI/MFLO read would see stale HI/LO. It sits in EX between the issue pipes and the `multplier`/`divider` instances.

---
 rtl/mdu_sched.sv | 137 +++++++++++++
 tb/tb_mdu_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// Round-robin scheduler sharing one multiplier/divider pair between two issue
// pipes; launches the chosen unit, follows its done handshake, commits HI/LO once.
module mdu_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_div,
  input  logic        req1_div,
  input  logic        req0_signed,
  input  logic        req1_signed,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_grant,
  output logic        req1_grant,
  output logic        req0_stall,
  output logic        req1_stall,
  input  logic        hilo_rd_i,
  output logic        hilo_rd_stall,
  output logic [1:0]  mult_op,
  output logic [1:0]  div_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [63:0] mult_result,
  input  logic [63:0] div_result,
  output logic        hilo_wen,
  output logic [63:0] hilo_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_START,
    S_RUN,
    S_COMMIT
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_kill;
  logic        r_kind_div;
  logic [1:0]  r_mult_op;
  logic [1:0]  r_div_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_res;

  logic        w_can_grant;
  logic        w_g0;
  logic        w_g1;
  logic        w_grant;
  logic        w_req_div;
  logic        w_req_signed;
  logic [1:0]  w_req_op;
  logic        w_sel_done;
  logic [63:0] w_sel_result;

  // rst_n gating keeps the combinational grant/stall outputs at 0 during reset
  assign w_can_grant = rst_n & ~flush_i & (r_state == S_IDLE);
  assign w_g0        = w_can_grant & req0_valid & (~req1_valid | r_last);
  assign w_g1        = w_can_grant & req1_valid & (~req0_valid | ~r_last);
  assign w_grant     = w_g0 | w_g1;

  assign w_req_div    = w_g1 ? req1_div    : req0_div;
  assign w_req_signed = w_g1 ? req1_signed : req0_signed;
  assign w_req_op     = w_req_signed ? 2'b10 : 2'b01;

  assign w_sel_done   = r_kind_div ? div_done   : mult_done;
  assign w_sel_result = r_kind_div ? div_result : mult_result;

  // r_last doubles as the owner of the in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_kill     <= 1'b0;
      r_kind_div <= 1'b0;
      r_mult_op  <= 2'b00;
      r_div_op   <= 2'b00;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_res      <= 64'd0;
    end else begin
      r_mult_op <= 2'b00;
      r_div_op  <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_a        <= w_g1 ? req1_a : req0_a;
            r_b        <= w_g1 ? req1_b : req0_b;
            r_kind_div <= w_req_div;
            r_last     <= w_g1;
            r_mult_op  <= w_req_div ? 2'b00 : w_req_op;
            r_div_op   <= w_req_div ? w_req_op : 2'b00;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE:  r_state <= S_START;
        S_START:  if (!w_sel_done) r_state <= S_RUN;
        S_RUN: begin
          if (w_sel_done) begin
            r_res   <= w_sel_result;
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase

      if (r_state == S_COMMIT)
        r_kill <= 1'b0;
      else if (r_state != S_IDLE && flush_i)
        r_kill <= 1'b1;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign req0_grant    = w_g0;
  assign req1_grant    = w_g1;
  assign req0_stall    = rst_n & req0_valid & ~w_g0;
  assign req1_stall    = rst_n & req1_valid & ~w_g1;
  // a reader alongside a grant would otherwise see the old HI/LO
  assign hilo_rd_stall = hilo_rd_i & (busy | w_grant);
  assign mult_op       = r_mult_op;
  assign div_op        = r_div_op;
  assign mdu_a         = r_a;
  assign mdu_b         = r_b;
  assign hilo_wen      = (r_state == S_COMMIT) & ~r_kill & ~flush_i;
  assign hilo_result   = r_res;

endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: directed requests against behavioural mult/div unit
// models, with a scoreboard monitor checking every HI/LO write.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        req0_valid, req1_valid, req0_div, req1_div, req0_signed, req1_signed;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_grant, req1_grant, req0_stall, req1_stall;
  logic        hilo_rd_i, hilo_rd_stall;
  logic [1:0]  mult_op, div_op;
  logic [31:0] mdu_a, mdu_b;
  logic        mult_done, div_done;
  logic [63:0] mult_result, div_result;
  logic        hilo_wen;
  logic [63:0] hilo_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  int mult_lat = 2;
  int div_lat  = 2;
  int m_cnt, d_cnt;
  logic [31:0] dq, dr;

  always #5 clk = ~clk;

  mdu_sched dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_div(req0_div), .req1_div(req1_div),
    .req0_signed(req0_signed), .req1_signed(req1_signed),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_grant(req0_grant), .req1_grant(req1_grant),
    .req0_stall(req0_stall), .req1_stall(req1_stall),
    .hilo_rd_i(hilo_rd_i), .hilo_rd_stall(hilo_rd_stall),
    .mult_op(mult_op), .div_op(div_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mult_done(mult_done), .div_done(div_done),
    .mult_result(mult_result), .div_result(div_result),
    .hilo_wen(hilo_wen), .hilo_result(hilo_result), .busy(busy)
  );

  // Unit models: done drops for exactly *_lat cycles after the op pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_done   <= 1'b1;
      m_cnt       <= 0;
      mult_result <= 64'd0;
    end else if (mult_op != 2'b00) begin
      mult_done <= 1'b0;
      m_cnt     <= mult_lat;
      if (mult_op == 2'b10)
        mult_result <= {{32{mdu_a[31]}}, mdu_a} * {{32{mdu_b[31]}}, mdu_b};
      else
        mult_result <= {32'd0, mdu_a} * {32'd0, mdu_b};
    end else if (!mult_done) begin
      if (m_cnt == 1) mult_done <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    dq = 32'd0;
    dr = 32'd0;
    if (div_op == 2'b10) begin
      dq = $signed(mdu_a) / $signed(mdu_b);
      dr = $signed(mdu_a) % $signed(mdu_b);
    end else if (mdu_b != 32'd0) begin
      dq = mdu_a / mdu_b;
      dr = mdu_a % mdu_b;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_done   <= 1'b1;
      d_cnt      <= 0;
      div_result <= 64'd0;
    end else if (div_op != 2'b00) begin
      div_done   <= 1'b0;
      d_cnt      <= div_lat;
      div_result <= {dr, dq};
    end else if (!div_done) begin
      if (d_cnt == 1) div_done <= 1'b1;
      d_cnt <= d_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (hilo_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hilo_unexpected: got write %h expected none", hilo_result);
      end else begin
        chk("hilo_result", hilo_result, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req0_valid = 0; req1_valid = 0;
    req0_div = 0; req1_div = 0; req0_signed = 0; req1_signed = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!busy) break;
    end
    chk("wait_idle_busy", busy, 0);
  endtask

  task automatic run_single(input string tag, input bit who, input bit dv, input bit sg,
                            input logic [31:0] a, input logic [31:0] b, input int lat,
                            input logic [63:0] exp, input bit rd, input int flush_at);
    logic [1:0] op_exp;
    op_exp = sg ? 2'b10 : 2'b01;
    if (dv) div_lat = lat; else mult_lat = lat;
    if (flush_at < 0) exp_q.push_back(exp);
    step();
    if (who) begin
      req1_valid = 1; req1_div = dv; req1_signed = sg; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_div = dv; req0_signed = sg; req0_a = a; req0_b = b;
    end
    hilo_rd_i = rd;
    flush_i   = 0;
    smp();
    chk({tag, "_grant"}, who ? req1_grant : req0_grant, 1);
    chk({tag, "_stall"}, who ? req1_stall : req0_stall, 0);
    chk({tag, "_rdstall_g"}, hilo_rd_stall, rd);
    step();
    clear_reqs();
    smp();
    chk({tag, "_op"}, dv ? div_op : mult_op, op_exp);
    chk({tag, "_otherop"}, dv ? mult_op : div_op, 0);
    for (int k = 2; k <= lat + 4; k++) begin
      step();
      flush_i = (k == flush_at);
      smp();
      chk($sformatf("%s_wen_c%0d", tag, k), hilo_wen, (k == lat + 3) && (flush_at < 0));
      chk($sformatf("%s_busy_c%0d", tag, k), busy, (k <= lat + 3));
      chk($sformatf("%s_ops_c%0d", tag, k), {mult_op, div_op}, 0);
      if (rd) chk($sformatf("%s_rdstall_c%0d", tag, k), hilo_rd_stall, (k <= lat + 3));
    end
    step();
    flush_i   = 0;
    hilo_rd_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; flush_i = 0; hilo_rd_i = 0;
    clear_reqs();
    req0_valid = 1; req1_valid = 1;
    repeat (2) smp();
    chk("rst_grant0", req0_grant, 0);
    chk("rst_grant1", req1_grant, 0);
    chk("rst_stall0", req0_stall, 0);
    chk("rst_stall1", req1_stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", {mult_op, div_op}, 0);
    chk("rst_mdu_ab", {mdu_a, mdu_b}, 0);
    chk("rst_hilo", {63'd0, hilo_wen} | hilo_result, 0);
    step();
    clear_reqs();
    rst_n = 1;

    // Tie: both held, req0 wins first, spacing L+4 = 6 cycles
    mult_lat = 2;
    exp_q.push_back(64'h0000_0000_0000_001E);
    exp_q.push_back(64'h0000_0000_0000_000C);
    exp_q.push_back(64'h0000_0000_0000_001E);
    step();
    req0_valid = 1; req0_div = 0; req0_signed = 1; req0_a = 5; req0_b = 6;
    req1_valid = 1; req1_div = 0; req1_signed = 0; req1_a = 3; req1_b = 4;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      if (c == 7) req1_valid = 0;
      smp();
      chk($sformatf("tie_g0_c%0d", c), req0_grant, (c == 0 || c == 12));
      chk($sformatf("tie_g1_c%0d", c), req1_grant, (c == 6));
      chk($sformatf("tie_s0_c%0d", c), req0_stall, (c != 0 && c != 12));
      chk($sformatf("tie_s1_c%0d", c), req1_stall, (c < 6));
    end
    step();
    clear_reqs();
    wait_idle();

    run_single("mult_s",  0, 0, 1, 32'hFFFF_FFFE, 32'd3, 4, 64'hFFFF_FFFF_FFFF_FFFA, 0, -1);
    run_single("divu",    1, 1, 0, 32'd7, 32'd2, 3, 64'h0000_0001_0000_0003, 0, -1);
    run_single("div_s",   0, 1, 1, 32'hFFFF_FFF9, 32'd2, 2, 64'hFFFF_FFFF_FFFF_FFFD, 0, -1);
    run_single("multu_l1", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, 0, -1);
    run_single("rdstall", 0, 0, 0, 32'h0001_0000, 32'h0001_0000, 2, 64'h0000_0001_0000_0000, 1, -1);
    run_single("flush_run", 0, 1, 1, 32'd100, 32'd7, 4, 64'd0, 0, 4);
    run_single("after_fl", 1, 1, 0, 32'd100, 32'd7, 2, 64'h0000_0002_0000_000E, 0, -1);
    run_single("flush_cm", 0, 0, 1, 32'd3, 32'd3, 2, 64'd0, 0, 5);

    // Flush in IDLE holds off the grant
    mult_lat = 2;
    exp_q.push_back(64'h0000_0000_FFFF_FFFE);
    step();
    req0_valid = 1; req0_div = 0; req0_signed = 1; req0_a = 32'h7FFF_FFFF; req0_b = 2;
    flush_i = 1;
    smp();
    chk("idleflush_grant", req0_grant, 0);
    chk("idleflush_stall", req0_stall, 1);
    step();
    flush_i = 0;
    smp();
    chk("idleflush_grant_after", req0_grant, 1);
    step();
    clear_reqs();
    wait_idle();

    // Asynchronous reset in the middle of RUN
    div_lat = 6;
    step();
    req0_valid = 1; req0_div = 1; req0_signed = 0; req0_a = 50; req0_b = 5;
    smp();
    chk("rstrun_grant", req0_grant, 1);
    step();
    clear_reqs();
    repeat (3) step();
    hilo_rd_i  = 1;
    req1_valid = 1; req1_div = 0; req1_signed = 0; req1_a = 9; req1_b = 9;
    rst_n = 0;
    #1;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_ops", {mult_op, div_op}, 0);
    chk("rstrun_mdu_ab", {mdu_a, mdu_b}, 0);
    chk("rstrun_wen", hilo_wen, 0);
    chk("rstrun_result", hilo_result, 0);
    chk("rstrun_grant1", req1_grant, 0);
    chk("rstrun_stall1", req1_stall, 0);
    chk("rstrun_rdstall", hilo_rd_stall, 0);
    mult_lat = 2;
    exp_q.push_back(64'd81);
    step();
    rst_n = 1;
    hilo_rd_i = 0;
    smp();
    chk("rstrun_regrant", req1_grant, 1);
    step();
    clear_reqs();
    wait_idle();

    repeat (3) smp();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
